ins_decoder: RTL

INS_DECODER -- requirements
Module: ins_decoder

---
 rtl/ins_decoder.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ins_decoder.sv
// Instruction decoder: accepts 64-bit words and dispatches load/calc/save fields or applies layer
// config once downstream units are idle. Define INS_ERR_CHECK_EN to enable illegal-opcode trapping.
module ins_decoder #(
    parameter int unsigned INST_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [INST_W-1:0] ins,
    input  logic              ins_valid,
    output logic              ins_ready,

    output logic              ld_valid,
    input  logic              ld_ready,
    output logic [3:0]        ld_op,
    output logic [5:0]        ld_buf_id,
    output logic [7:0]        ld_size,
    output logic [31:0]       ld_addr,

    output logic              calc_valid,
    input  logic              calc_ready,
    output logic              calc_cut_y,
    output logic              calc_is_new,
    output logic [5:0]        calc_pe_id,
    output logic [3:0]        calc_pad_code,
    output logic [7:0]        calc_pix_num,
    output logic [7:0]        calc_idx_num,

    output logic              sv_valid,
    input  logic              sv_ready,
    output logic [3:0]        sv_op,
    output logic [5:0]        sv_buf_id,
    output logic [31:0]       sv_addr,

    input  logic              ld_busy,
    input  logic              calc_busy,
    input  logic              sv_busy,

    output logic [3:0]        cfg_layer_type,
    output logic              cfg_pool,
    output logic              cfg_relu,
    output logic [3:0]        cfg_ich_seg,
    output logic [3:0]        cfg_och_seg,
    output logic [7:0]        cfg_in_w,
    output logic [7:0]        cfg_out_w,

    output logic [CNT_W-1:0]  ins_cnt,
    output logic              err_flag,
    output logic [INST_W-1:0] err_ins
);

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StCfgWait
    } state_e;

    state_e             state_q, state_d;
    logic               ready_q;
    logic               ld_valid_q, ld_valid_d;
    logic               calc_valid_q, calc_valid_d;
    logic               sv_valid_q, sv_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [29:0]        cfg_word_q;
    logic               xfer, illegal;
    logic               load_ld, load_calc, load_sv, latch_cfg, apply_cfg;
    logic [1:0]         ins_type;
    logic [3:0]         ins_op;

    assign ins_type   = ins[63:62];
    assign ins_op     = ins[61:58];
    assign xfer       = ins_valid && ready_q;
    assign ins_ready  = ready_q;
    assign ld_valid   = ld_valid_q;
    assign calc_valid = calc_valid_q;
    assign sv_valid   = sv_valid_q;
    assign ins_cnt    = cnt_q;

    always_comb begin
        illegal = 1'b0;
`ifdef INS_ERR_CHECK_EN
        unique case (ins_type)
            2'b00:   illegal = !(ins_op inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7});
            2'b10:   illegal = !(ins_op inside {4'd0, 4'd8, 4'd9, 4'd10, 4'd11});
            2'b11:   illegal = (ins_op > 4'd5);
            default: illegal = 1'b0;
        endcase
`endif
    end

    always_comb begin
        state_d      = state_q;
        ld_valid_d   = ld_valid_q;
        calc_valid_d = calc_valid_q;
        sv_valid_d   = sv_valid_q;
        cnt_d        = cnt_q;
        load_ld      = 1'b0;
        load_calc    = 1'b0;
        load_sv      = 1'b0;
        latch_cfg    = 1'b0;
        apply_cfg    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Illegal words are swallowed here; the error registers record them.
                if (xfer && !illegal) begin
                    unique case (ins_type)
                        2'b00: begin
                            load_ld    = 1'b1;
                            ld_valid_d = 1'b1;
                            state_d    = StDispatch;
                        end
                        2'b01: begin
                            load_calc    = 1'b1;
                            calc_valid_d = 1'b1;
                            state_d      = StDispatch;
                        end
                        2'b10: begin
                            load_sv    = 1'b1;
                            sv_valid_d = 1'b1;
                            state_d    = StDispatch;
                        end
                        default: begin
                            latch_cfg = 1'b1;
                            state_d   = StCfgWait;
                        end
                    endcase
                end
            end
            StDispatch: begin
                if ((ld_valid_q && ld_ready) || (calc_valid_q && calc_ready) ||
                    (sv_valid_q && sv_ready)) begin
                    ld_valid_d   = 1'b0;
                    calc_valid_d = 1'b0;
                    sv_valid_d   = 1'b0;
                    cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d      = StIdle;
                end
            end
            StCfgWait: begin
                if (!ld_busy && !calc_busy && !sv_busy) begin
                    apply_cfg = 1'b1;
                    cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ins_ready is registered so it stays low throughout reset and rises on the first edge after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ready_q      <= 1'b0;
            ld_valid_q   <= 1'b0;
            calc_valid_q <= 1'b0;
            sv_valid_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= (state_d == StIdle);
            ld_valid_q   <= ld_valid_d;
            calc_valid_q <= calc_valid_d;
            sv_valid_q   <= sv_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_op         <= '0;
            ld_buf_id     <= '0;
            ld_size       <= '0;
            ld_addr       <= '0;
            calc_cut_y    <= 1'b0;
            calc_is_new   <= 1'b0;
            calc_pe_id    <= '0;
            calc_pad_code <= '0;
            calc_pix_num  <= '0;
            calc_idx_num  <= '0;
            sv_op         <= '0;
            sv_buf_id     <= '0;
            sv_addr       <= '0;
        end else begin
            if (load_ld) begin
                ld_op     <= ins[61:58];
                ld_buf_id <= ins[57:52];
                ld_size   <= ins[39:32];
                ld_addr   <= ins[31:0];
            end
            if (load_calc) begin
                calc_cut_y    <= ins[59];
                calc_is_new   <= ins[58];
                calc_pe_id    <= ins[57:52];
                calc_pad_code <= ins[51:48];
                calc_pix_num  <= ins[47:40];
                calc_idx_num  <= ins[39:32];
            end
            if (load_sv) begin
                sv_op     <= ins[61:58];
                sv_buf_id <= ins[57:52];
                sv_addr   <= ins[31:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_word_q     <= '0;
            cfg_layer_type <= '0;
            cfg_pool       <= 1'b0;
            cfg_relu       <= 1'b0;
            cfg_ich_seg    <= '0;
            cfg_och_seg    <= '0;
            cfg_in_w       <= '0;
            cfg_out_w      <= '0;
        end else begin
            if (latch_cfg) begin
                cfg_word_q <= ins[61:32];
            end
            if (apply_cfg) begin
                cfg_layer_type <= cfg_word_q[29:26];
                cfg_pool       <= cfg_word_q[25];
                cfg_relu       <= cfg_word_q[24];
                cfg_ich_seg    <= cfg_word_q[23:20];
                cfg_och_seg    <= cfg_word_q[19:16];
                cfg_in_w       <= cfg_word_q[15:8];
                cfg_out_w      <= cfg_word_q[7:0];
            end
        end
    end

`ifdef INS_ERR_CHECK_EN
    logic set_err;
    assign set_err = (state_q == StIdle) && xfer && illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
            err_ins  <= '0;
        end else if (set_err) begin
            // Only the first offending word is kept.
            if (!err_flag) begin
                err_ins <= ins;
            end
            err_flag <= 1'b1;
        end
    end
`else
    assign err_flag = 1'b0;
    assign err_ins  = '0;
`endif

endmodule
